// File: rtl/conv_1x1_stream_tx.sv
// Streams one layer's weights, then one channel-planar feature map, from a 1-cycle read port to conv_1x1 inputs.
// Optional CONV_TX_SKIP_WEIGHT_EN adds skip_weights_i (sampled with start_i) to jump straight to pixels.
module conv_1x1_stream_tx #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 64,
    parameter int IMAGE_HEIGHT    = 64,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 128,
    parameter int ADDR_WIDTH      = 24,
    parameter int WEIGHT_BASE     = 0,
    parameter int PIXEL_BASE      = 'h10000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
`ifdef CONV_TX_SKIP_WEIGHT_EN
    input  logic                  skip_weights_i,
`endif
    input  logic                  pause_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [DATA_WIDTH-1:0] weight_out_o,
    output logic                  valid_weight_out_o,
    output logic [DATA_WIDTH-1:0] pxl_out_o,
    output logic                  valid_out_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int NUM_WEIGHTS = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
    localparam int IMAGE_SIZE  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int WCNT_W      = $clog2(NUM_WEIGHTS + 1);
    localparam int PCNT_W      = $clog2(IMAGE_SIZE + 1);
    localparam int CCNT_W      = $clog2(CHANNEL_NUM_IN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WEIGHT, S_PIXEL, S_DRAIN0, S_DRAIN1, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   w_cnt_q, w_cnt_d;
    logic [PCNT_W-1:0]   p_cnt_q, p_cnt_d;
    logic [CCNT_W-1:0]   c_cnt_q, c_cnt_d;
    logic                tag1_vld_q, tag1_pix_q;
    logic                valid_weight_q, valid_pxl_q;
    logic [DATA_WIDTH-1:0] weight_q, pxl_q;
    logic                skip_w;
    logic                last_weight, last_chan, last_pixel;

`ifdef CONV_TX_SKIP_WEIGHT_EN
    assign skip_w = skip_weights_i;
`else
    assign skip_w = 1'b0;
`endif

    assign last_weight = (w_cnt_q == WCNT_W'(NUM_WEIGHTS - 1));
    assign last_chan   = (c_cnt_q == CCNT_W'(CHANNEL_NUM_IN - 1));
    assign last_pixel  = (p_cnt_q == PCNT_W'(IMAGE_SIZE - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = skip_w ? S_PIXEL : S_WEIGHT;
            S_WEIGHT: if (mem_rd_en_o && last_weight) state_d = S_PIXEL;
            S_PIXEL:  if (mem_rd_en_o && last_chan && last_pixel) state_d = S_DRAIN0;
            S_DRAIN0: state_d = S_DRAIN1;
            S_DRAIN1: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // The address is held while paused; only the read strobe is gated.
    always_comb begin
        mem_rd_en_o = 1'b0;
        mem_addr_o  = '0;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        case (state_q)
            S_WEIGHT: begin
                mem_rd_en_o = ~pause_i;
                mem_addr_o  = ADDR_WIDTH'(WEIGHT_BASE) + ADDR_WIDTH'(w_cnt_q);
            end
            S_PIXEL: begin
                mem_rd_en_o = ~pause_i;
                mem_addr_o  = ADDR_WIDTH'(PIXEL_BASE)
                            + ADDR_WIDTH'(c_cnt_q) * ADDR_WIDTH'(IMAGE_SIZE)
                            + ADDR_WIDTH'(p_cnt_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_cnt_d = w_cnt_q;
        p_cnt_d = p_cnt_q;
        c_cnt_d = c_cnt_q;
        if (state_q == S_IDLE) begin
            w_cnt_d = '0;
            p_cnt_d = '0;
            c_cnt_d = '0;
        end else if (mem_rd_en_o) begin
            if (state_q == S_WEIGHT) begin
                w_cnt_d = w_cnt_q + WCNT_W'(1);
            end else if (last_chan) begin
                c_cnt_d = '0;
                p_cnt_d = p_cnt_q + PCNT_W'(1);
            end else begin
                c_cnt_d = c_cnt_q + CCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_cnt_q <= '0;
            p_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            w_cnt_q <= w_cnt_d;
            p_cnt_q <= p_cnt_d;
            c_cnt_q <= c_cnt_d;
        end
    end

    // Stage 1 tags the outstanding read; stage 2 steers the returned word to its output.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag1_vld_q     <= 1'b0;
            tag1_pix_q     <= 1'b0;
            valid_weight_q <= 1'b0;
            valid_pxl_q    <= 1'b0;
            weight_q       <= '0;
            pxl_q          <= '0;
        end else begin
            tag1_vld_q     <= mem_rd_en_o;
            tag1_pix_q     <= (state_q == S_PIXEL);
            valid_weight_q <= tag1_vld_q & ~tag1_pix_q;
            valid_pxl_q    <= tag1_vld_q & tag1_pix_q;
            if (tag1_vld_q && !tag1_pix_q) weight_q <= mem_rd_data_i;
            if (tag1_vld_q && tag1_pix_q)  pxl_q    <= mem_rd_data_i;
        end
    end

    assign weight_out_o       = weight_q;
    assign valid_weight_out_o = valid_weight_q;
    assign pxl_out_o          = pxl_q;
    assign valid_out_o        = valid_pxl_q;

endmodule

// File: tb/tb_conv_1x1_stream_tx.sv
// Randomized scoreboard bench for conv_1x1_stream_tx on a 2x2x2x2 layer with data = address memory.
module tb_conv_1x1_stream_tx;
    localparam int DW = 32, AW = 24, IW = 2, IH = 2, CI = 2, CO = 2, WB = 0, PB = 16;
    localparam int NW = CI * CO, IMG = IW * IH;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0;
    logic mem_rd_en, valid_weight_out, valid_out, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0, weight_out, pxl_out;
`ifdef CONV_TX_SKIP_WEIGHT_EN
    logic skip_weights = 1'b0;
`endif

    conv_1x1_stream_tx #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .CHANNEL_NUM_IN(CI),
        .CHANNEL_NUM_OUT(CO), .ADDR_WIDTH(AW), .WEIGHT_BASE(WB), .PIXEL_BASE(PB)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
`ifdef CONV_TX_SKIP_WEIGHT_EN
        .skip_weights_i(skip_weights),
`endif
        .pause_i(pause), .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rd_data_i(mem_rd_data),
        .weight_out_o(weight_out), .valid_weight_out_o(valid_weight_out), .pxl_out_o(pxl_out),
        .valid_out_o(valid_out), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_d = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= reset;
        if (mem_rd_en) mem_rd_data <= DW'(mem_addr);
    end

    typedef struct {
        bit          pix;
        logic [31:0] dat;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    int   done_q[$];
    int   checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_zero();
        chk("rst_rd_en", 64'(mem_rd_en), 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_vw", 64'(valid_weight_out), 0);
        chk("rst_vp", 64'(valid_out), 0);
        chk("rst_wout", 64'(weight_out), 0);
        chk("rst_pout", 64'(pxl_out), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents data or done.
    logic [31:0] last_w = '0, last_p = '0;
    always @(negedge clk) begin
        chk("valid_excl", 64'(valid_weight_out & valid_out), 0);
        if (valid_weight_out || valid_out) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: vw=%0b vp=%0b w=%0h p=%0h with empty queue (cycle %0d)",
                         valid_weight_out, valid_out, weight_out, pxl_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_kind", 64'(valid_out), 64'(e.pix));
                chk("out_data", 64'(e.pix ? pxl_out : weight_out), 64'(e.dat));
                chk("out_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (!rst_d) begin
            if (!valid_weight_out) chk("w_hold", 64'(weight_out), 64'(last_w));
            if (!valid_out)        chk("p_hold", 64'(pxl_out), 64'(last_p));
        end
        last_w = weight_out;
        last_p = pxl_out;
        if (done) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: done high at cycle %0d", cyc);
            end else begin
                chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that starts the first IDLE cycle.
    // mode 0: no pause, 1: pause at relative cycles 4..5, 2: random pause.
    task automatic run(input int mode, input int restart_rel, input int reset_rel, input bit skip);
        bit pat[256];
        int t, sc, done_rel;
        for (int i = 0; i < 256; i++)
            pat[i] = (mode == 1) ? (i == 4 || i == 5) :
                     (mode == 2 && i < 64) ? ($urandom_range(3) == 0) : 1'b0;
        sc = cyc;
        t  = 1;
        if (!skip) begin
            for (int k = 0; k < NW; k++) begin
                while (pat[t]) t++;
                exp_q.push_back('{pix: 1'b0, dat: 32'(WB + k), cyc: sc + t + 2});
                t++;
            end
        end
        for (int p = 0; p < IMG; p++) begin
            for (int c = 0; c < CI; c++) begin
                while (pat[t]) t++;
                exp_q.push_back('{pix: 1'b1, dat: 32'(PB + c * IMG + p), cyc: sc + t + 2});
                t++;
            end
        end
        done_rel = t + 2;
        done_q.push_back(sc + done_rel);
`ifdef CONV_TX_SKIP_WEIGHT_EN
        skip_weights = skip;
`endif
        for (int rel = 0; rel <= done_rel; rel++) begin
            start = (rel == 0) || (rel == restart_rel);
            pause = pat[rel];
            if (rel == 1) chk("busy_active", 64'(busy), 1);
            if (rel == reset_rel) reset = 1'b1;
            @(posedge clk);
            #1;
            if (rel == reset_rel) begin
                reset = 1'b0;
                start = 1'b0;
                pause = 1'b0;
                exp_q.delete();
                done_q.delete();
                chk_zero();
                return;
            end
        end
        start = 1'b0;
        pause = 1'b0;
        chk("busy_idle", 64'(busy), 0);
        chk("exp_drained", 64'(exp_q.size()), 0);
        chk("done_drained", 64'(done_q.size()), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(3);
        chk_zero();
        reset = 1'b0;
        run(0, -1, -1, 1'b0);
        run(0, -1, -1, 1'b0);
        idle(2);
        run(1, -1, -1, 1'b0);
        run(0, 8, -1, 1'b0);
        idle(1);
        run(0, -1, 9, 1'b0);
        idle(3);
        run(0, -1, -1, 1'b0);
        run(0, -1, 4, 1'b0);
        run(0, -1, -1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            idle(int'($urandom_range(3)));
            run(2, int'($urandom_range(1, 20)), -1, 1'b0);
        end
`ifdef CONV_TX_SKIP_WEIGHT_EN
        idle(1);
        run(0, -1, -1, 1'b1);
        run(2, -1, -1, 1'b1);
        run(0, -1, -1, 1'b0);
`endif
        idle(4);
        chk("final_exp_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
